if_id_skid_stage: RTL and testbench
===================================

// Module: if_id_skid_stage
// PURPOSE
//  Parametrised IF->ID pipeline stage with valid/ready handshake and a 2-entry skid buffer.
//  Decouples fetch from decode back-pressure without a combinational ready path.
//  Honours one selectable hold_flag_i bit and a pipeline flush.
//  Keeps a saturating stall-cycle counter. Sits between the fetch unit and the decoder.
// PARAMETERS
//  ADDR_W    64            PC width
//  INST_W    32            instruction width
//  HOLD_W    3             width of hold_flag_i bus
//  HOLD_BIT  1             index of hold_flag_i that stalls this stage
//  NOP_INST  32'h00000013  instruction driven on dn_inst_o when stage is empty
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst_n        in   1       synchronous reset, active-high (1 = reset)
//  flush_i      in   1       kill all held entries and the incoming beat
//  hold_flag_i  in   HOLD_W  pipeline hold bus; bit HOLD_BIT stalls output
//  up_valid_i   in   1       fetch beat valid
//  up_ready_o   out  1       stage can accept a beat (= !skid_valid, registered source)
//  up_pc_i      in   ADDR_W  fetch PC
//  up_inst_i    in   INST_W  fetched instruction
//  dn_valid_o   out  1       decode beat valid (= main_valid & ~hold)
//  dn_ready_i   in   1       decoder accepts beat
//  dn_pc_o      out  ADDR_W  PC to decode
//  dn_inst_o    out  INST_W  instruction to decode
//  stall_cnt_o  out  32      saturating count of stalled cycles
// BEHAVIOUR
//  - hold = hold_flag_i[HOLD_BIT]; up_fire = up_valid_i & up_ready_o;
//    dn_fire = main_valid & dn_ready_i & ~hold.
//  - Storage: main reg (drives dn_*) + skid reg. States EMPTY / ONE (main) / TWO (main+skid).
//  - EMPTY: up_fire -> ONE, main <= up.
//  - ONE:
//      up_fire & dn_fire   -> ONE, main <= up.
//      up_fire & !dn_fire  -> TWO, skid <= up.
//      !up_fire & dn_fire  -> EMPTY.
//      else                -> hold.
//  - TWO: up_ready_o = 0.
//      dn_fire   -> ONE, main <= skid.
//      else      -> hold.
//  - Latency: 1 cycle up_fire -> dn_valid_o. Throughput: 1 beat/cycle when unstalled.
//    Order strictly preserved; no loss, no duplication.
//  - On entering EMPTY: dn_inst_o <= NOP_INST; dn_pc_o keeps its last value.
//  - Priority each cycle: rst_n > flush_i > normal transitions.
//  - flush_i = 1: next cycle state is EMPTY, dn_inst_o = NOP_INST, dn_pc_o = 0.
//    The beat presented in the flush cycle is dropped even if up_fire = 1.
//    stall_cnt_o is not affected by flush.
//  - hold masks dn_valid_o combinationally. Upstream keeps filling the skid while a hold is active.
//  - stall_cnt_o: +1 when main_valid & ~(dn_ready_i & ~hold); saturates at 32'hFFFF_FFFF.
//  - Reset values: state EMPTY, dn_valid_o = 0, up_ready_o = 1 (after reset cycle),
//    dn_pc_o = 0, dn_inst_o = NOP_INST, stall_cnt_o = 0.
//    Inputs are ignored in any cycle where rst_n = 1. Reset is valid mid-operation from any state.
// TESTING
//  1. rst_n = 1 for 2 cycles -> dn_valid_o = 0, dn_inst_o = 0x13, dn_pc_o = 0,
//     up_ready_o = 1, stall_cnt_o = 0.
//  2. dn_ready_i = 1; push pc = 0x8000_0000 + 4k, inst = 0x100 + k, k = 0..7 ->
//     each appears one cycle later in order; up_ready_o stays 1; stall_cnt_o = 0.
//  3. dn_ready_i = 0; push A, B, present C -> state TWO, up_ready_o = 0, C stalled.
//     Raise dn_ready_i -> A, B, C delivered in order with no gaps or duplicates.
//  4. One beat held, dn_ready_i = 1, hold bit high 3 cycles -> dn_valid_o = 0 for those cycles;
//     stall_cnt_o += 3; beat delivered in the cycle after hold drops.
//  5. In TWO, assert flush_i with up_valid_i = 1 (pc 0x8000_0040) -> next cycle dn_valid_o = 0,
//     dn_inst_o = 0x13, up_ready_o = 1; pc 0x8000_0040 never appears. Next push delivered normally.
//  6. rst_n = 1 while in TWO with stall_cnt_o > 0 -> outputs identical to test 1.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage: valid/ready handshake with a two-entry (main + skid) buffer,
// selectable hold bit, flush, and a saturating stall-cycle counter.
module if_id_skid_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                HOLD_W   = 3,
    parameter int                HOLD_BIT = 1,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [ADDR_W-1:0] up_pc_i,
    input  logic [INST_W-1:0] up_inst_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [ADDR_W-1:0] dn_pc_o,
    output logic [INST_W-1:0] dn_inst_o,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_KEEP = 2'd0,
        M_UP   = 2'd1,
        M_SKID = 2'd2,
        M_NOP  = 2'd3
    } main_sel_t;

    state_t            r_state;
    logic              r_main_valid;
    logic              r_up_ready;
    logic [ADDR_W-1:0] r_main_pc;
    logic [INST_W-1:0] r_main_inst;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [INST_W-1:0] r_skid_inst;
    logic [31:0]       r_stall_cnt;

    state_t            w_next_state;
    main_sel_t         w_main_sel;
    logic              w_skid_load;
    logic              w_hold;
    logic              w_up_fire;
    logic              w_dn_fire;
    logic              w_stall;

    assign w_hold    = hold_flag_i[HOLD_BIT];
    assign w_up_fire = up_valid_i & r_up_ready;
    assign w_dn_fire = r_main_valid & dn_ready_i & ~w_hold;
    assign w_stall   = r_main_valid & ~(dn_ready_i & ~w_hold);

    assign up_ready_o  = r_up_ready;
    assign dn_valid_o  = r_main_valid & ~w_hold;
    assign dn_pc_o     = r_main_pc;
    assign dn_inst_o   = r_main_inst;
    assign stall_cnt_o = r_stall_cnt;

    // Next-state and buffer steering decode
    always_comb begin
        w_next_state = r_state;
        w_main_sel   = M_KEEP;
        w_skid_load  = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_up_fire) begin
                    w_next_state = S_ONE;
                    w_main_sel   = M_UP;
                end else begin
                    w_next_state = S_EMPTY;
                end
            end
            S_ONE: begin
                if (w_up_fire && w_dn_fire) begin
                    w_main_sel = M_UP;
                end else if (w_up_fire) begin
                    w_next_state = S_TWO;
                    w_skid_load  = 1'b1;
                end else if (w_dn_fire) begin
                    w_next_state = S_EMPTY;
                    w_main_sel   = M_NOP;
                end else begin
                    w_next_state = S_ONE;
                end
            end
            S_TWO: begin
                if (w_dn_fire) begin
                    w_next_state = S_ONE;
                    w_main_sel   = M_SKID;
                end else begin
                    w_next_state = S_TWO;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
                w_main_sel   = M_NOP;
            end
        endcase
    end

    // State register; ready/valid are registered from the next state so no comb path reaches up_ready_o
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= S_EMPTY;
            r_main_valid <= 1'b0;
            r_up_ready   <= 1'b1;
        end else if (flush_i) begin
            r_state      <= S_EMPTY;
            r_main_valid <= 1'b0;
            r_up_ready   <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_main_valid <= (w_next_state != S_EMPTY);
            r_up_ready   <= (w_next_state != S_TWO);
        end
    end

    // Main and skid payload registers; the PC is kept when draining to empty, cleared on flush
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_main_pc   <= '0;
            r_main_inst <= NOP_INST;
            r_skid_pc   <= '0;
            r_skid_inst <= NOP_INST;
        end else if (flush_i) begin
            r_main_pc   <= '0;
            r_main_inst <= NOP_INST;
            r_skid_pc   <= r_skid_pc;
            r_skid_inst <= r_skid_inst;
        end else begin
            case (w_main_sel)
                M_UP: begin
                    r_main_pc   <= up_pc_i;
                    r_main_inst <= up_inst_i;
                end
                M_SKID: begin
                    r_main_pc   <= r_skid_pc;
                    r_main_inst <= r_skid_inst;
                end
                M_NOP: begin
                    r_main_pc   <= r_main_pc;
                    r_main_inst <= NOP_INST;
                end
                default: begin
                    r_main_pc   <= r_main_pc;
                    r_main_inst <= r_main_inst;
                end
            endcase
            if (w_skid_load) begin
                r_skid_pc   <= up_pc_i;
                r_skid_inst <= up_inst_i;
            end else begin
                r_skid_pc   <= r_skid_pc;
                r_skid_inst <= r_skid_inst;
            end
        end
    end

    // Saturating stall counter; counts through flush, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed scenarios plus random traffic, checked against a
// queue-based reference model of a two-deep in-order buffer.
module tb_if_id_skid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [2:0]  hold_flag_i;
    logic        up_valid_i;
    logic        up_ready_o;
    logic [63:0] up_pc_i;
    logic [31:0] up_inst_i;
    logic        dn_valid_o;
    logic        dn_ready_i;
    logic [63:0] dn_pc_o;
    logic [31:0] dn_inst_o;
    logic [31:0] stall_cnt_o;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t sb[$];
    logic [63:0] last_pc = 64'd0;
    logic [31:0] exp_stall = 32'd0;
    bit    armed = 1'b0;

    if_id_skid_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .hold_flag_i (hold_flag_i),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_pc_i     (up_pc_i),
        .up_inst_i   (up_inst_i),
        .dn_valid_o  (dn_valid_o),
        .dn_ready_i  (dn_ready_i),
        .dn_pc_o     (dn_pc_o),
        .dn_inst_o   (dn_inst_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare outputs with the model mid-cycle, then advance the model for the next edge
    always @(negedge clk) begin
        bit dfire;
        bit ufire;
        if (armed) begin
            chk("up_ready", {63'd0, up_ready_o}, {63'd0, sb.size() < 2});
            chk("dn_valid", {63'd0, dn_valid_o}, {63'd0, (sb.size() > 0) && !hold_flag_i[1]});
            if (sb.size() > 0) begin
                chk("dn_pc", dn_pc_o, sb[0].pc);
                chk("dn_inst", {32'd0, dn_inst_o}, {32'd0, sb[0].inst});
            end else begin
                chk("empty_pc", dn_pc_o, last_pc);
                chk("empty_inst", {32'd0, dn_inst_o}, {32'd0, NOP});
            end
            chk("stall_cnt", {32'd0, stall_cnt_o}, {32'd0, exp_stall});
        end
        if (rst_n) begin
            sb.delete();
            last_pc   = 64'd0;
            exp_stall = 32'd0;
            armed     = 1'b1;
        end else if (armed) begin
            if ((sb.size() > 0) && !(dn_ready_i && !hold_flag_i[1]) && (exp_stall != 32'hFFFF_FFFF))
                exp_stall = exp_stall + 32'd1;
            if (flush_i) begin
                sb.delete();
                last_pc = 64'd0;
            end else begin
                dfire = (sb.size() > 0) && dn_ready_i && !hold_flag_i[1];
                ufire = up_valid_i && (sb.size() < 2);
                if (dfire) begin
                    last_pc = sb[0].pc;
                    void'(sb.pop_front());
                end
                if (ufire) sb.push_back('{up_pc_i, up_inst_i});
            end
        end
    end

    task automatic drive(input logic r, input logic f, input logic [2:0] h, input logic v,
                         input logic [63:0] pc, input logic [31:0] inst, input logic dr);
        @(posedge clk);
        #1;
        rst_n       = r;
        flush_i     = f;
        hold_flag_i = h;
        up_valid_i  = v;
        up_pc_i     = pc;
        up_inst_i   = inst;
        dn_ready_i  = dr;
    endtask

    task automatic idle(input logic dr, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'b000, 1'b0, 64'd0, 32'd0, dr);
    endtask

    // Present a beat until the stage can take it; dr_after applies once up_ready has been seen low
    task automatic push(input logic [63:0] pc, input logic [31:0] inst, input logic dr,
                        input logic dr_after);
        int tries = 0;
        logic d = dr;
        forever begin
            drive(1'b0, 1'b0, 3'b000, 1'b1, pc, inst, d);
            if (up_ready_o) break;
            tries++;
            if (tries >= 2) d = dr_after;
            if (tries > 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL push_timeout pc %h: got ready 0 expected ready 1", pc);
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; flush_i = 1'b0; hold_flag_i = 3'b000; up_valid_i = 1'b0;
        up_pc_i = 64'd0; up_inst_i = 32'd0; dn_ready_i = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 1'b0, 64'd0, 32'd0, 1'b0);
        idle(1'b0, 2);

        for (int k = 0; k < 8; k++)
            push(64'h8000_0000 + 64'(4 * k), 32'h100 + 32'(k), 1'b1, 1'b1);
        idle(1'b1, 2);

        push(64'h8000_0100, 32'hA, 1'b0, 1'b0);
        push(64'h8000_0104, 32'hB, 1'b0, 1'b0);
        push(64'h8000_0108, 32'hC, 1'b0, 1'b1);
        idle(1'b1, 3);

        drive(1'b0, 1'b0, 3'b010, 1'b1, 64'h8000_0200, 32'hD, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 3'b010, 1'b0, 64'd0, 32'd0, 1'b1);
        idle(1'b1, 2);

        push(64'h8000_0300, 32'hE, 1'b0, 1'b0);
        push(64'h8000_0304, 32'hF, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'b000, 1'b1, 64'h8000_0040, 32'h40, 1'b0);
        push(64'h8000_0308, 32'h10, 1'b1, 1'b1);
        idle(1'b1, 2);

        push(64'h8000_0400, 32'h11, 1'b0, 1'b0);
        push(64'h8000_0404, 32'h12, 1'b0, 1'b0);
        idle(1'b0, 4);
        drive(1'b1, 1'b0, 3'b000, 1'b1, 64'h8000_0408, 32'h13, 1'b1);
        drive(1'b1, 1'b0, 3'b000, 1'b0, 64'd0, 32'd0, 1'b0);
        idle(1'b0, 2);

        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  {$urandom, $urandom}, $urandom, ($urandom_range(0, 3) != 0));
        idle(1'b1, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
